mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the CPU core and the unified 16-bit instruction/data memory. It accepts instruction-fetch requests and data load/store requests through two independent req/valid ports. It serialises them onto the memory's one port (ON, W, ADDR, DATA_IN, DATA_OUT) and returns read data, or a write acknowledge, to the requester. Out-of-range addresses are screened before they reach the memory array.

## Interface
- WORD_SIZE, 16, data and address width
- MEM_DEPTH, 16, number of implemented memory words; addresses ≥ MEM_DEPTH are out of range
- CLK  in  1  clock, all state changes on posedge
- RST_N  in  1  reset, synchronous, active-low
- I_REQ  in  1  fetch request, level, held until I_VALID
- I_ADDR  in  WORD_SIZE  fetch address, stable while I_REQ
- I_RDATA  out  WORD_SIZE  fetched word, meaningful when I_VALID
- I_VALID  out  1  one-cycle fetch completion pulse
- D_REQ  in  1  data request, level, held until D_VALID
- D_WE  in  1  1 = store, 0 = load; stable while D_REQ
- D_ADDR  in  WORD_SIZE  data address
- D_WDATA  in  WORD_SIZE  store data
- D_RDATA  out  WORD_SIZE  load data, meaningful when D_VALID and !D_WE
- D_VALID  out  1  one-cycle data completion pulse, loads and stores
- ERR  out  1  one-cycle pulse, coincident with I_VALID/D_VALID, for an out-of-range address
- MEM_ON  out  1  memory enable
- MEM_W  out  1  memory write strobe
- MEM_ADDR  out  WORD_SIZE  memory address
- MEM_DIN  out  WORD_SIZE  memory write data
- MEM_DOUT  in  WORD_SIZE  memory read data; combinational; high-Z when !MEM_ON or MEM_W

## Operation
- FSM states: IDLE, ACC_I (fetch read), ACC_DR (data read), ACC_DW (data write). Track `last_d` = last grant went to the data port.
- IDLE, eligible requests only. A request is eligible when its REQ is high and its own VALID is not high in that cycle; REQ seen alongside its VALID is the old request and is ignored.
  - D only → ACC_DR or ACC_DW, selected by D_WE.
  - I only → ACC_I.
  - Both, last_d=0 → data grant. Both, last_d=1 → fetch grant. Strict alternation under contention.
- Grant in range:
  - Registered for the next cycle: MEM_ON=1, MEM_ADDR=granted address, MEM_W=D_WE for a data grant (0 for fetch), MEM_DIN=D_WDATA on a write (else 0).
  - FSM enters the ACC state.
- Grant out of range (address ≥ MEM_DEPTH):
  - No ACC state; MEM_ON stays 0.
  - Next cycle: VALID of the granted port=1, ERR=1, RDATA=16'h0000.
  - last_d is updated.
- ACC_I / ACC_DR: at the closing posedge, MEM_DOUT is captured into I_RDATA/D_RDATA and that VALID is set. ACC_DW: the memory writes at that posedge and D_VALID is set. In all three, the same edge clears MEM_ON, MEM_W and MEM_DIN; FSM → IDLE.
- RDATA registers hold their value until the next completion on the same port.
- MEM_DOUT is sampled only at the end of ACC_I/ACC_DR; high-Z at any other time is harmless.
- Reset values: FSM IDLE, last_d=0, all outputs 0 (I_RDATA, D_RDATA, MEM_ADDR, MEM_DIN = 16'h0000; all strobes 0).
- Reset mid-operation:
  - Reset applied at the closing edge of ACC_DW: the memory write still completes, since the memory samples MEM_W=1 at that edge, but no D_VALID is issued.
  - Reset applied in ACC_I/ACC_DR: data is discarded, no VALID.
- A request changed or dropped before its VALID is a protocol violation; behaviour is undefined and the bench flags it.

## Timing
- Request sampled at edge N (IDLE) → memory access cycle N..N+1 → VALID high cycle N+1..N+2. Latency: 2 cycles from sampling REQ to VALID.
- Out-of-range request: VALID+ERR 1 cycle after sampling.
- The IDLE cycle in which VALID is high can issue the next grant. A waiting other-port request is granted there, giving peak throughput of 1 access per 2 cycles.
- MEM_W is never high without MEM_ON. MEM_ON is high for exactly one cycle per in-range access.
- I_VALID and D_VALID are never high in the same cycle.

## Test plan
- Fetch after reset: I_REQ, I_ADDR=0 with the memory preloaded to 16'h1004 → MEM_ON=1 and MEM_ADDR=0 in cycle 1; I_VALID=1, I_RDATA=16'h1004 in cycle 2; ERR=0.
- Store then load: D_WE=1, D_ADDR=5, D_WDATA=16'hBEEF → one MEM_W=1 cycle and D_VALID. Then D_WE=0, D_ADDR=5 → D_RDATA=16'hBEEF.
- Contention: I_REQ and D_REQ held continuously from reset → grants D, I, D, I. VALIDs alternate every 2 cycles, never coincident.
- Out of range: D_REQ with D_ADDR=16'h0010, MEM_DEPTH=16 → MEM_ON stays 0; D_VALID=1, ERR=1, D_RDATA=0 one cycle later.
- Reset during ACC_DW to address 3 with data 16'h00AA → no D_VALID; memory[3]=16'h00AA; all outputs 0 the cycle after reset; a subsequent fetch serves normally.
- Held REQ after VALID: requester keeps I_REQ high one extra cycle after I_VALID → exactly one access issued for the original request; the extra cycle is not treated as a new grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU instruction-fetch and data load/store requests
// onto the single port of a unified memory. Each access returns either the
// read word or a write acknowledge. Out-of-range addresses are answered with
// an error pulse and never reach the memory array.
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int MEM_DEPTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  // instruction-fetch port
  input  logic                 I_REQ,
  input  logic [WORD_SIZE-1:0] I_ADDR,
  output logic [WORD_SIZE-1:0] I_RDATA,
  output logic                 I_VALID,
  // data load/store port
  input  logic                 D_REQ,
  input  logic                 D_WE,
  input  logic [WORD_SIZE-1:0] D_ADDR,
  input  logic [WORD_SIZE-1:0] D_WDATA,
  output logic [WORD_SIZE-1:0] D_RDATA,
  output logic                 D_VALID,
  output logic                 ERR,
  // memory port
  output logic                 MEM_ON,
  output logic                 MEM_W,
  output logic [WORD_SIZE-1:0] MEM_ADDR,
  output logic [WORD_SIZE-1:0] MEM_DIN,
  input  logic [WORD_SIZE-1:0] MEM_DOUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_I  = 2'd1,
    ACC_DR = 2'd2,
    ACC_DW = 2'd3
  } state_t;

  localparam logic [WORD_SIZE-1:0] DEPTH_LIM = WORD_SIZE'(MEM_DEPTH);

  state_t state;
  logic   last_d;   // last grant went to the data port

  // A request raised in the same cycle as its own VALID is the tail of the
  // request just completed, not a new one.
  logic i_elig, d_elig, d_wins, i_oor, d_oor;

  assign i_elig = I_REQ && !I_VALID;
  assign d_elig = D_REQ && !D_VALID;
  // Data wins when it is alone, or under contention when fetch had the last turn.
  assign d_wins = d_elig && (!i_elig || !last_d);
  assign i_oor  = (I_ADDR >= DEPTH_LIM);
  assign d_oor  = (D_ADDR >= DEPTH_LIM);

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      I_RDATA  <= '0;
      I_VALID  <= 1'b0;
      D_RDATA  <= '0;
      D_VALID  <= 1'b0;
      ERR      <= 1'b0;
      MEM_ON   <= 1'b0;
      MEM_W    <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DIN  <= '0;
    end else begin
      // completion strobes are single-cycle pulses
      I_VALID <= 1'b0;
      D_VALID <= 1'b0;
      ERR     <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wins) begin
            last_d <= 1'b1;
            if (d_oor) begin
              D_VALID <= 1'b1;
              ERR     <= 1'b1;
              D_RDATA <= '0;
            end else begin
              MEM_ON   <= 1'b1;
              MEM_W    <= D_WE;
              MEM_ADDR <= D_ADDR;
              MEM_DIN  <= D_WE ? D_WDATA : '0;
              state    <= D_WE ? ACC_DW : ACC_DR;
            end
          end else if (i_elig) begin
            last_d <= 1'b0;
            if (i_oor) begin
              I_VALID <= 1'b1;
              ERR     <= 1'b1;
              I_RDATA <= '0;
            end else begin
              MEM_ON   <= 1'b1;
              MEM_W    <= 1'b0;
              MEM_ADDR <= I_ADDR;
              MEM_DIN  <= '0;
              state    <= ACC_I;
            end
          end
        end
        ACC_I: begin
          I_RDATA <= MEM_DOUT;
          I_VALID <= 1'b1;
          MEM_ON  <= 1'b0;
          MEM_W   <= 1'b0;
          MEM_DIN <= '0;
          state   <= IDLE;
        end
        ACC_DR: begin
          D_RDATA <= MEM_DOUT;
          D_VALID <= 1'b1;
          MEM_ON  <= 1'b0;
          MEM_W   <= 1'b0;
          MEM_DIN <= '0;
          state   <= IDLE;
        end
        ACC_DW: begin
          // the memory commits the write on this same edge
          D_VALID <= 1'b1;
          MEM_ON  <= 1'b0;
          MEM_W   <= 1'b0;
          MEM_DIN <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a
// behavioural 16-word memory attached to the memory port.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        I_REQ, D_REQ, D_WE;
  logic [15:0] I_ADDR, D_ADDR, D_WDATA;
  logic [15:0] I_RDATA, D_RDATA, MEM_ADDR, MEM_DIN, MEM_DOUT;
  logic        I_VALID, D_VALID, ERR, MEM_ON, MEM_W;

  mem_arbiter #(.WORD_SIZE(16), .MEM_DEPTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_VALID(I_VALID),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_VALID(D_VALID), .ERR(ERR),
    .MEM_ON(MEM_ON), .MEM_W(MEM_W), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // Memory model: backdoor preload port plus the DUT write port.
  logic [15:0] mem [0:15];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_addr = 4'd0;
  logic [15:0] bd_data = 16'h0;

  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (MEM_ON && MEM_W && MEM_ADDR < 16) mem[MEM_ADDR[3:0]] <= MEM_DIN;
  end

  // Garbage outside a read access stands in for the high-Z bus.
  assign MEM_DOUT = (MEM_ON && !MEM_W) ? mem[MEM_ADDR[3:0]] : 16'hDEAD;

  typedef struct {
    bit          port;      // 0 = fetch, 1 = data
    logic [15:0] data;
    bit          chk_data;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_vcyc = 0;
  int   gap = 0;
  int   acc_cnt = 0;
  bit   saw_valid = 0;
  bit   auto_drop = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input bit port, input logic [15:0] data, input bit chk_data, input bit err);
    exp_t e;
    e.port = port; e.data = data; e.chk_data = chk_data; e.err = err;
    q.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, score completions.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    saw_valid = 0;
    if (MEM_ON) acc_cnt++;
    if (MEM_W) chk("w_without_on", {31'b0, MEM_ON}, 32'd1);
    if (I_VALID || D_VALID) begin
      saw_valid = 1;
      gap = cyc - last_vcyc;
      last_vcyc = cyc;
      chk("valid_overlap", {31'b0, I_VALID & D_VALID}, 32'd0);
      chk("sb_nonempty", {31'b0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("port", {31'b0, D_VALID}, {31'b0, e.port});
        chk("err", {31'b0, ERR}, {31'b0, e.err});
        if (e.chk_data) chk("rdata", {16'b0, e.port ? D_RDATA : I_RDATA}, {16'b0, e.data});
      end
      if (auto_drop) begin
        if (I_VALID) I_REQ = 1'b0;
        if (D_VALID) D_REQ = 1'b0;
      end
    end else if (ERR) begin
      chk("err_without_valid", {31'b0, ERR}, 32'd0);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge CLK);
    #1;
    bd_we = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    I_REQ = 1'b0; I_ADDR = 16'h0;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 16'h0; D_WDATA = 16'h0;
    preload(4'd0, 16'h1004);
    preload(4'd3, 16'h0000);
    preload(4'd5, 16'h0000);
    preload(4'd7, 16'h1234);
    preload(4'd15, 16'h0F0F);
    tick();
    tick();

    // reset state
    chk("rst_i_valid", {31'b0, I_VALID}, 32'd0);
    chk("rst_d_valid", {31'b0, D_VALID}, 32'd0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    chk("rst_mem_on_w", {30'b0, MEM_ON, MEM_W}, 32'd0);
    chk("rst_mem_addr_din", {MEM_ADDR, MEM_DIN}, 32'd0);
    chk("rst_rdata", {I_RDATA, D_RDATA}, 32'd0);

    // fetch after reset
    RST_N = 1'b1;
    I_REQ = 1'b1; I_ADDR = 16'h0000;
    push(1'b0, 16'h1004, 1'b1, 1'b0);
    tick();
    chk("fetch_mem_on", {31'b0, MEM_ON}, 32'd1);
    chk("fetch_mem_addr", {16'b0, MEM_ADDR}, 32'h0);
    chk("fetch_mem_w", {31'b0, MEM_W}, 32'd0);
    tick();
    chk("fetch_latency", {31'b0, I_VALID}, 32'd1);
    chk("fetch_q_empty", q.size(), 32'd0);
    tick();

    // store then load
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0005; D_WDATA = 16'hBEEF;
    push(1'b1, 16'h0, 1'b0, 1'b0);
    tick();
    chk("store_mem_w", {30'b0, MEM_ON, MEM_W}, 32'd3);
    chk("store_addr_din", {MEM_ADDR, MEM_DIN}, {16'h0005, 16'hBEEF});
    tick();
    chk("store_valid", {31'b0, D_VALID}, 32'd1);
    chk("store_mem_w_cleared", {30'b0, MEM_ON, MEM_W}, 32'd0);
    chk("store_mem5", {16'b0, mem[5]}, 32'h0000BEEF);
    chk("store_rdata_hold", {16'b0, D_RDATA}, 32'h0);
    tick();
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0005;
    push(1'b1, 16'hBEEF, 1'b1, 1'b0);
    tick();
    chk("load_mem_w", {30'b0, MEM_ON, MEM_W}, 32'd2);
    drain(4);
    tick();

    // out of range data, then fetch, then last in-range word
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0010;
    push(1'b1, 16'h0000, 1'b1, 1'b1);
    tick();
    chk("oor_d_mem_on", {31'b0, MEM_ON}, 32'd0);
    chk("oor_d_latency", {30'b0, D_VALID, ERR}, 32'd3);
    tick();
    I_REQ = 1'b1; I_ADDR = 16'hFFFF;
    push(1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    chk("oor_i_mem_on", {31'b0, MEM_ON}, 32'd0);
    chk("oor_i_q_empty", q.size(), 32'd0);
    tick();
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h000F;
    push(1'b1, 16'h0F0F, 1'b1, 1'b0);
    drain(4);
    tick();

    // contention from reset: D, I, D, I with VALIDs 2 cycles apart
    RST_N = 1'b0;
    auto_drop = 0;
    I_REQ = 1'b1; I_ADDR = 16'h0000;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0007;
    tick();
    tick();
    push(1'b1, 16'h1234, 1'b1, 1'b0);
    push(1'b0, 16'h1004, 1'b1, 1'b0);
    push(1'b1, 16'h1234, 1'b1, 1'b0);
    push(1'b0, 16'h1004, 1'b1, 1'b0);
    RST_N = 1'b1;
    last_vcyc = cyc;
    begin
      int n = 0;
      int nv = 0;
      while (q.size() != 0 && n < 20) begin
        tick();
        n++;
        if (saw_valid) begin
          nv++;
          if (nv > 1) chk("contention_gap", gap, 32'd2);
        end
      end
      chk("contention_done", q.size(), 32'd0);
    end
    I_REQ = 1'b0; D_REQ = 1'b0;
    auto_drop = 1;
    tick();
    tick();

    // reset during ACC_DW
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0003; D_WDATA = 16'h00AA;
    tick();
    chk("dw_mem_w", {30'b0, MEM_ON, MEM_W}, 32'd3);
    RST_N = 1'b0;
    tick();
    chk("dw_rst_no_valid", {30'b0, I_VALID, D_VALID}, 32'd0);
    chk("dw_rst_mem_ctl", {29'b0, MEM_ON, MEM_W, ERR}, 32'd0);
    chk("dw_rst_addr_din", {MEM_ADDR, MEM_DIN}, 32'd0);
    chk("dw_rst_rdata", {I_RDATA, D_RDATA}, 32'd0);
    chk("dw_rst_mem3", {16'b0, mem[3]}, 32'h000000AA);
    D_REQ = 1'b0; D_WE = 1'b0;
    RST_N = 1'b1;
    I_REQ = 1'b1; I_ADDR = 16'h0003;
    push(1'b0, 16'h00AA, 1'b1, 1'b0);
    drain(4);
    tick();

    // held I_REQ through the VALID cycle issues only one access
    auto_drop = 0;
    acc_cnt = 0;
    I_REQ = 1'b1; I_ADDR = 16'h0007;
    push(1'b0, 16'h1234, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    I_REQ = 1'b0;
    tick();
    tick();
    tick();
    chk("held_req_accesses", acc_cnt, 32'd1);
    chk("held_req_q_empty", q.size(), 32'd0);
    auto_drop = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
